// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF / Execute memory port arbiter:
// RV32I width codes, response owner encoding and store-lane helpers.
package mem_port_arbiter_pkg;

    // RV32I load width codes (func3)
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // RV32I store width codes (func3)
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // Consecutive D grants allowed while IF waits
    localparam int unsigned MAX_STREAK_DEFAULT = 4;

    // Owner of the access granted in the previous cycle
    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIF   = 2'd1,
        OwnD    = 2'd2
    } owner_e;

    // Misaligned address or illegal width code on a D request
    function automatic logic d_req_error(input logic       write,
                                         input logic [2:0] func3,
                                         input logic [1:0] addr_lo);
        logic err;
        case (func3)
            LB:      err = 1'b0;
            LH:      err = addr_lo[0];
            LW:      err = (addr_lo != 2'b00);
            LBU:     err = write;
            LHU:     err = write | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Lane write enables for a store of the given width
    function automatic logic [3:0] store_byte_en(input logic [2:0] func3,
                                                 input logic [1:0] addr_lo);
        logic [3:0] be;
        case (func3)
            SB:      be = 4'b0001 << addr_lo;
            SH:      be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated across every lane it may occupy
    function automatic logic [31:0] store_wdata(input logic [2:0]  func3,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (func3)
            SB:      d = {4{wdata[7:0]}};
            SH:      d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_load_aligner.sv
// Load aligner: picks the byte/halfword addressed by the latched low address
// bits out of the raw memory word and sign- or zero-extends it.
module load_aligner
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Extend the selected lane according to the load width code
    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (func3_i)
            LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LH: begin
                data_o = {{16{half_sel[15]}}, half_sel};
                err_o  = addr_lo_i[0];
            end
            LW: begin
                data_o = rdata_i;
                err_o  = (addr_lo_i != 2'b00);
            end
            LBU: data_o = {24'd0, byte_sel};
            LHU: begin
                data_o = {16'd0, half_sel};
                err_o  = addr_lo_i[0];
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port 32-bit memory between instruction fetch
// and the Execute-stage load/store path. D has priority; a streak counter
// hands the port to IF after MAX_STREAK consecutive D grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STREAK = MAX_STREAK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifReqValid,
    input  logic [ADDR_WIDTH-1:0] ifReqAddr,
    output logic                  ifReqReady,
    output logic                  ifRespValid,
    output logic [DATA_WIDTH-1:0] ifRespData,
    input  logic                  dReqValid,
    input  logic                  dReqWrite,
    input  logic [2:0]            dReqFunc3,
    input  logic [ADDR_WIDTH-1:0] dReqAddr,
    input  logic [DATA_WIDTH-1:0] dReqWData,
    output logic                  dReqReady,
    output logic                  dRespValid,
    output logic [DATA_WIDTH-1:0] dRespData,
    output logic                  dRespErr,
    output logic                  memEnable,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [3:0]            memByteEn,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic [DATA_WIDTH-1:0] memRData
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    owner_e              owner_q, owner_d;
    logic [2:0]          func3_q, func3_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic                write_q, write_d;
    logic                err_q, err_d;

    logic                if_grant;
    logic                d_grant;
    logic                d_err;
    logic [31:0]         load_data;
    logic                load_err;

    // Fetch addresses are word aligned; the low bits carry no information
    logic unused_if_addr_lo;
    assign unused_if_addr_lo = ^ifReqAddr[1:0];

    // Grant selection: D wins unless IF has waited through a full streak
    always_comb begin
        d_grant  = !reset && dReqValid && !(ifReqValid && (streak_q == STREAK_MAX));
        if_grant = !reset && ifReqValid && !d_grant;
        d_err    = d_req_error(dReqWrite, dReqFunc3, dReqAddr[1:0]);
    end

    assign dReqReady  = d_grant;
    assign ifReqReady = if_grant;

    // Drive the memory port for the granted requester; errored D requests
    // are accepted but never reach the memory
    always_comb begin
        memEnable = 1'b0;
        memWrite  = 1'b0;
        memAddr   = '0;
        memByteEn = '0;
        memWData  = '0;
        if (d_grant) begin
            if (!d_err) begin
                memEnable = 1'b1;
                memWrite  = dReqWrite;
                memAddr   = {dReqAddr[ADDR_WIDTH-1:2], 2'b00};
                if (dReqWrite) begin
                    memByteEn = store_byte_en(dReqFunc3, dReqAddr[1:0]);
                    memWData  = store_wdata(dReqFunc3, dReqWData);
                end
            end
        end else if (if_grant) begin
            memEnable = 1'b1;
            memAddr   = {ifReqAddr[ADDR_WIDTH-1:2], 2'b00};
        end
    end

    // Next streak count and the fields the response cycle needs
    always_comb begin
        if (if_grant || !ifReqValid) begin
            streak_d = '0;
        end else if (d_grant && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end else begin
            streak_d = streak_q;
        end

        if (d_grant) begin
            owner_d = OwnD;
        end else if (if_grant) begin
            owner_d = OwnIF;
        end else begin
            owner_d = OwnNone;
        end
        func3_d   = dReqFunc3;
        addr_lo_d = dReqAddr[1:0];
        write_d   = dReqWrite;
        err_d     = d_err;
    end

    // Streak counter and response-owner register
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q  <= '0;
            owner_q   <= OwnNone;
            func3_q   <= '0;
            addr_lo_q <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            owner_q   <= owner_d;
            func3_q   <= func3_d;
            addr_lo_q <= addr_lo_d;
            write_q   <= write_d;
            err_q     <= err_d;
        end
    end

    load_aligner u_load_aligner (
        .func3_i   (func3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (memRData),
        .data_o    (load_data),
        .err_o     (load_err)
    );

    // Responses are gated by reset so a pending one never escapes
    always_comb begin
        ifRespValid = !reset && (owner_q == OwnIF);
        dRespValid  = !reset && (owner_q == OwnD);
        ifRespData  = ifRespValid ? memRData : '0;
        dRespErr    = dRespValid && (err_q || (!write_q && load_err));
        dRespData   = (dRespValid && !write_q && !dRespErr) ? load_data : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by
// random IF/D traffic, checked against a byte-level memory reference model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifReqValid = 1'b0;
    logic [31:0] ifReqAddr = 32'h1000;
    logic        ifReqReady;
    logic        ifRespValid;
    logic [31:0] ifRespData;
    logic        dReqValid = 1'b0;
    logic        dReqWrite = 1'b0;
    logic [2:0]  dReqFunc3 = 3'd0;
    logic [31:0] dReqAddr = 32'h1000;
    logic [31:0] dReqWData = 32'd0;
    logic        dReqReady;
    logic        dRespValid;
    logic [31:0] dRespData;
    logic        dRespErr;
    logic        memEnable;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWData;
    logic [31:0] memRData = 32'd0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_STREAK (MAXS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ifReqValid  (ifReqValid),
        .ifReqAddr   (ifReqAddr),
        .ifReqReady  (ifReqReady),
        .ifRespValid (ifRespValid),
        .ifRespData  (ifRespData),
        .dReqValid   (dReqValid),
        .dReqWrite   (dReqWrite),
        .dReqFunc3   (dReqFunc3),
        .dReqAddr    (dReqAddr),
        .dReqWData   (dReqWData),
        .dReqReady   (dReqReady),
        .dRespValid  (dRespValid),
        .dRespData   (dRespData),
        .dRespErr    (dRespErr),
        .memEnable   (memEnable),
        .memWrite    (memWrite),
        .memAddr     (memAddr),
        .memByteEn   (memByteEn),
        .memWData    (memWData),
        .memRData    (memRData)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
    } dreq_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    dreq_t       dq[$];
    logic [31:0] iq[$];
    exp_t        sbq[$];

    logic [7:0]  gold_b [0:63];   // reference memory, bytes at 0x1000..0x103F
    logic [31:0] mem_w  [0:15];   // memory macro model driven by the DUT

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int streak_m = 0;
    bit if_gnt_m = 0;
    bit d_gnt_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro: synchronous write with lane enables, one-cycle read latency
    always @(posedge clk) begin
        if (memEnable) begin
            if (memWrite) begin
                for (int b = 0; b < 4; b++)
                    if (memByteEn[b]) mem_w[memAddr[5:2]][8*b +: 8] <= memWData[8*b +: 8];
            end else begin
                memRData <= mem_w[memAddr[5:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit acc_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1;
        if (wr && f3[2]) return 1;
        return (int'(a[5:0]) % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] gold_read(input logic [31:0] a, input int n, input bit sgn);
        logic [31:0] v = 32'd0;
        int off = int'(a[5:0]);
        for (int k = 0; k < n; k++) v[8*k +: 8] = gold_b[off + k];
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // Monitor (responses) followed by the arbitration/memory reference model
    exp_t        e;
    bit          d_g, i_g, aerr;
    int          n;
    logic [3:0]  be_m;
    logic [31:0] wd_m;
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs", 32'(|{ifReqReady, dReqReady, ifRespValid, ifRespData,
                dRespValid, dRespData, dRespErr, memEnable, memWrite, memAddr,
                memByteEn, memWData}), 32'd0);
            sbq.delete();
            streak_m = 0;
            if_gnt_m = 0;
            d_gnt_m  = 0;
        end else begin
            if (ifRespValid || dRespValid) begin
                chk("resp_exclusive", 32'(ifRespValid && dRespValid), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'(ifRespValid | dRespValid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_owner", 32'(dRespValid), 32'(e.is_d));
                    if (e.is_d) begin
                        chk("d_data", dRespData, e.data);
                        chk("d_err", 32'(dRespErr), 32'(e.err));
                    end else begin
                        chk("if_data", ifRespData, e.data);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                chk("missing_resp", 32'(ifRespValid | dRespValid), 32'd1);
                void'(sbq.pop_front());
            end

            d_g = dReqValid && !(ifReqValid && streak_m == MAXS);
            i_g = ifReqValid && !d_g;
            chk("dReqReady", 32'(dReqReady), 32'(d_g));
            chk("ifReqReady", 32'(ifReqReady), 32'(i_g));

            if (d_g) begin
                aerr = acc_err(dReqWrite, dReqFunc3, dReqAddr);
                n    = acc_size(dReqFunc3);
                chk("memEnable_d", 32'(memEnable), 32'(!aerr));
                chk("memWrite_d", 32'(memWrite), 32'(dReqWrite && !aerr));
                if (aerr) begin
                    sbq.push_back('{is_d: 1'b1, data: 32'd0, err: 1'b1, due: cyc + 1});
                end else begin
                    chk("memAddr_d", memAddr, {dReqAddr[31:2], 2'b00});
                    be_m = 4'd0;
                    if (dReqWrite) begin
                        for (int k = 0; k < n; k++) be_m[(int'(dReqAddr[1:0]) + k) % 4] = 1'b1;
                        wd_m = (n == 1) ? {4{dReqWData[7:0]}} :
                               (n == 2) ? {2{dReqWData[15:0]}} : dReqWData;
                        chk("memWData", memWData, wd_m);
                        for (int k = 0; k < n; k++)
                            gold_b[int'(dReqAddr[5:0]) + k] = dReqWData[8*k +: 8];
                        sbq.push_back('{is_d: 1'b1, data: 32'd0, err: 1'b0, due: cyc + 1});
                    end else begin
                        sbq.push_back('{is_d: 1'b1, data: gold_read(dReqAddr, n, !dReqFunc3[2]),
                                        err: 1'b0, due: cyc + 1});
                    end
                    chk("memByteEn", 32'(memByteEn), 32'(be_m));
                end
            end else if (i_g) begin
                chk("memEnable_if", 32'(memEnable), 32'd1);
                chk("memWrite_if", 32'(memWrite), 32'd0);
                chk("memAddr_if", memAddr, ifReqAddr);
                chk("memByteEn_if", 32'(memByteEn), 32'd0);
                sbq.push_back('{is_d: 1'b0, data: gold_read(ifReqAddr, 4, 1'b0), err: 1'b0, due: cyc + 1});
            end else begin
                chk("memEnable_idle", 32'(memEnable), 32'd0);
            end

            streak_m = (ifReqValid && d_g) ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
            d_gnt_m  = d_g;
            if_gnt_m = i_g;
        end
    end

    // One clock of stimulus: retire granted requests, present the next ones
    task automatic step();
        dreq_t r;
        @(posedge clk);
        #1;
        if (d_gnt_m)  dReqValid  = 1'b0;
        if (if_gnt_m) ifReqValid = 1'b0;
        if (!dReqValid && dq.size() > 0) begin
            r = dq.pop_front();
            dReqValid = 1'b1;
            dReqWrite = r.wr;
            dReqFunc3 = r.f3;
            dReqAddr  = r.addr;
            dReqWData = r.wd;
        end
        if (!ifReqValid && iq.size() > 0) begin
            ifReqAddr  = iq.pop_front();
            ifReqValid = 1'b1;
        end
    endtask

    function automatic dreq_t rand_d(input bit legal_load);
        dreq_t r;
        logic [2:0] codes [0:4];
        codes[0] = 3'd0; codes[1] = 3'd1; codes[2] = 3'd2; codes[3] = 3'd4; codes[4] = 3'd5;
        r.wr   = legal_load ? 1'b0 : 1'($urandom_range(0, 1));
        r.f3   = ($urandom_range(0, 7) == 0 && !legal_load) ? 3'($urandom_range(0, 7))
                                                             : codes[$urandom_range(0, 4)];
        r.addr = 32'h1000 + 32'($urandom_range(0, 63));
        if (legal_load) r.addr[1:0] = 2'b00;
        r.wd   = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] rand_if();
        return 32'h1000 + 32'($urandom_range(0, 15) * 4);
    endfunction

    task automatic drain();
        int guard = 0;
        while ((dq.size() > 0 || iq.size() > 0 || dReqValid || ifReqValid) && guard < 200) begin
            step();
            guard++;
        end
        chk("drain_bound", 32'(dq.size() + iq.size()), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) gold_b[i] = 8'($urandom);
        gold_b[8] = 8'h7F; gold_b[9] = 8'hFF; gold_b[10] = 8'h00; gold_b[11] = 8'h80;
        for (int i = 0; i < 16; i++)
            mem_w[i] = {gold_b[4*i+3], gold_b[4*i+2], gold_b[4*i+1], gold_b[4*i]};

        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset held two cycles while a lw response is pending
        dq.push_back('{wr: 1'b0, f3: 3'd2, addr: 32'h1004, wd: 32'd0});
        step();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();

        // sb 0x1003, then byte/halfword loads of 0x8000FF7F at 0x1008
        dq.push_back('{wr: 1'b1, f3: 3'd0, addr: 32'h1003, wd: 32'h0000_00AB});
        dq.push_back('{wr: 1'b0, f3: 3'd0, addr: 32'h1008, wd: 32'd0});
        dq.push_back('{wr: 1'b0, f3: 3'd0, addr: 32'h1009, wd: 32'd0});
        dq.push_back('{wr: 1'b0, f3: 3'd5, addr: 32'h100A, wd: 32'd0});
        dq.push_back('{wr: 1'b0, f3: 3'd1, addr: 32'h100A, wd: 32'd0});
        dq.push_back('{wr: 1'b0, f3: 3'd2, addr: 32'h1000, wd: 32'd0});
        // Misaligned lw and sh, illegal func3
        dq.push_back('{wr: 1'b0, f3: 3'd2, addr: 32'h1002, wd: 32'd0});
        dq.push_back('{wr: 1'b1, f3: 3'd1, addr: 32'h1011, wd: 32'h1234});
        dq.push_back('{wr: 1'b1, f3: 3'd4, addr: 32'h1010, wd: 32'h55});
        dq.push_back('{wr: 1'b0, f3: 3'd3, addr: 32'h1010, wd: 32'd0});
        drain();

        // Both requesters valid for ten cycles: DDDDI DDDDI
        for (int i = 0; i < 10; i++) dq.push_back(rand_d(1'b1));
        for (int i = 0; i < 4; i++) iq.push_back(rand_if());
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            #1;
            chk("grant_pattern", 32'({ifReqReady, dReqReady}), (i % 5 == 4) ? 32'd2 : 32'd1);
        end
        drain();

        // Alternating single-requester traffic
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) iq.push_back(rand_if());
            else dq.push_back(rand_d(1'b0));
            step();
        end
        drain();

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            if (dq.size() < 2 && $urandom_range(0, 2) != 0) dq.push_back(rand_d(1'b0));
            if (iq.size() < 2 && $urandom_range(0, 1) != 0) iq.push_back(rand_if());
            step();
        end
        drain();

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
